ipg_req_tx: RTL

- Requester-side serializer for the IPG memory protocol.
- Accepts one read or write request at a time.
- Builds the message: 16-bit header, then 64-bit address, then a 512-bit write payload for writes.
- Slices the message MSB-first into variable-length chunks sized to the idle-gap capacity the PHY announces each cycle. Chunks leave as (tx_ipg_data, tx_len) for insertion into the inter-packet gap.

---
 rtl/ipg_req_tx_if.sv | 26 ++
 rtl/ipg_req_tx.sv | 136 +++++++++++++
 2 files changed

// File: rtl/ipg_req_tx_if.sv
// Request, gap-offer and chunk-output bundle for the IPG requester serializer.
// master drives requests and gap offers; slave is the serializer itself.
interface ipg_req_tx_if;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [63:0]  req_addr;
    logic [511:0] req_wdata;
    logic         gap_valid;
    logic [5:0]   gap_bits;
    logic         tx_valid;
    logic [63:0]  tx_ipg_data;
    logic [5:0]   tx_len;
    logic         msg_done;
    logic         err_op;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, gap_valid, gap_bits,
        input  req_ready, tx_valid, tx_ipg_data, tx_len, msg_done, err_op
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, gap_valid, gap_bits,
        output req_ready, tx_valid, tx_ipg_data, tx_len, msg_done, err_op
    );
endinterface

// File: rtl/ipg_req_tx.sv
// IPG requester serializer: header, address and optional write payload are
// sliced MSB-first into chunks that fit the idle-gap capacity offered each cycle.
module ipg_req_tx (
    input  logic         clk,
    input  logic         reset,
    ipg_req_tx_if.slave  bus
);
    localparam int DATA_WIDTH = 64;

    typedef enum logic [1:0] {IDLE, HDR, ADDR, DATA} state_t;

    state_t       state;
    logic [15:0]  hdr_q;
    logic [63:0]  addr_sh;
    logic [511:0] data_sh;
    logic [6:0]   addr_rem;
    logic [9:0]   data_rem;

    logic                  gap_ok;
    logic                  use_c;
    logic                  last_c;
    logic [5:0]            len_c;
    logic [DATA_WIDTH-1:0] raw_c;
    logic [DATA_WIDTH-1:0] chunk_c;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path infers a latch.
        use_c  = 1'b0;
        last_c = 1'b0;
        len_c  = '0;
        raw_c  = '0;
        gap_ok = bus.gap_valid && (bus.gap_bits != '0);
        case (state)
            HDR: begin
                // The header must fit whole; leftover room carries leading address bits.
                use_c = gap_ok && (bus.gap_bits >= 6'd16);
                len_c = bus.gap_bits;
                raw_c = {hdr_q, addr_sh[63:16]};
            end
            ADDR: begin
                use_c  = gap_ok;
                len_c  = ({1'b0, bus.gap_bits} < addr_rem) ? bus.gap_bits : addr_rem[5:0];
                raw_c  = addr_sh;
                last_c = ({1'b0, len_c} == addr_rem);
            end
            DATA: begin
                use_c  = gap_ok;
                len_c  = ({4'b0, bus.gap_bits} < data_rem) ? bus.gap_bits : data_rem[5:0];
                raw_c  = data_sh[511:448];
                last_c = ({4'b0, len_c} == data_rem);
            end
            default: ;
        endcase
        chunk_c = raw_c & ~({DATA_WIDTH{1'b1}} >> len_c);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            // NOTE: the captured request is wide but is cleared anyway so an aborted message leaves nothing behind.
            hdr_q           <= '0;
            addr_sh         <= '0;
            data_sh         <= '0;
            addr_rem        <= '0;
            data_rem        <= '0;
            bus.req_ready   <= 1'b1;
            bus.tx_valid    <= 1'b0;
            bus.tx_ipg_data <= '0;
            bus.tx_len      <= '0;
            bus.msg_done    <= 1'b0;
            bus.err_op      <= 1'b0;
        end else begin
            bus.tx_valid    <= 1'b0;
            bus.tx_ipg_data <= '0;
            bus.tx_len      <= '0;
            bus.msg_done    <= 1'b0;
            bus.err_op      <= 1'b0;
            if (state != IDLE && use_c) begin
                bus.tx_valid    <= 1'b1;
                bus.tx_ipg_data <= chunk_c;
                bus.tx_len      <= len_c;
            end
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (bus.req_op[1]) begin
                            bus.err_op <= 1'b1;
                        end else begin
                            hdr_q         <= {bus.req_op, bus.req_op[0] ? 14'd512 : 14'd0};
                            addr_sh       <= bus.req_addr;
                            data_sh       <= bus.req_op[0] ? bus.req_wdata : '0;
                            bus.req_ready <= 1'b0;
                            state         <= HDR;
                        end
                    end
                end
                HDR: begin
                    if (use_c) begin
                        addr_sh  <= addr_sh << (len_c - 6'd16);
                        addr_rem <= 7'd80 - {1'b0, len_c};
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (use_c) begin
                        addr_sh  <= addr_sh << len_c;
                        addr_rem <= addr_rem - {1'b0, len_c};
                        if (last_c) begin
                            if (hdr_q[14]) begin
                                data_rem <= 10'd512;
                                state    <= DATA;
                            end else begin
                                bus.msg_done  <= 1'b1;
                                bus.req_ready <= 1'b1;
                                state         <= IDLE;
                            end
                        end
                    end
                end
                DATA: begin
                    if (use_c) begin
                        data_sh  <= data_sh << len_c;
                        data_rem <= data_rem - {4'b0, len_c};
                        if (last_c) begin
                            bus.msg_done  <= 1'b1;
                            bus.req_ready <= 1'b1;
                            state         <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
